// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide execution unit.
package muldiv_pkg;

    // Datapath width of the default build; CNT_W sizes its iteration counter.
    localparam int L_DEFAULT = 16;

    // Opcode values carried on ALUOpcode.
    localparam logic ALU_MUL = 1'b1;
    localparam logic ALU_DIV = 1'b0;

    // Counter width needed to count 0..l-1.
    function automatic int cnt_width(input int l);
        return (l > 1) ? $clog2(l) : 1;
    endfunction

    localparam int CNT_W = cnt_width(L_DEFAULT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage

// File: rtl/muldiv_exec_unit.sv
// Iterative unsigned multiply / restoring divide execution unit with an
// LUI shortcut. One operation in flight; valid/ready on both sides.
//
// state | meaning
// IDLE  | waiting for a request, in_ready = 1
// MUL   | shift-add multiply, one multiplier bit per cycle
// DIV   | restoring divide, one quotient bit per cycle
// DONE  | result presented with out_valid = 1 until out_ready
module muldiv_exec_unit
    import muldiv_pkg::*;
#(
    parameter int L = L_DEFAULT,
    parameter int P = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [P-1:0] ALUOpcode,
    input  logic         UseImmediate,
    input  logic         LoadUpperImmediate,
    input  logic [L-1:0] rs1,
    input  logic [L-1:0] rs2,
    input  logic [L-1:0] imm,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [L-1:0] result,
    output logic         div_by_zero
);

    // The default build uses the shared counter width directly.
    localparam int CW = (L == L_DEFAULT) ? CNT_W : cnt_width(L);

    state_t        state;
    logic [CW-1:0] cnt;
    // opa: multiplicand (MUL) or dividend shifting into quotient (DIV)
    // opb: multiplier shifting right (MUL) or divisor (DIV)
    // part: product accumulator (MUL) or partial remainder (DIV)
    logic [L-1:0]  opa;
    logic [L-1:0]  opb;
    logic [L-1:0]  part;

    logic [L-1:0]  opb_sel;
    logic          op_mul;
    logic          op_div;
    logic          last_iter;
    logic [L-1:0]  mul_part_nxt;
    logic [L:0]    rem_sh;
    logic [L:0]    trial;
    logic          div_ok;
    logic [L-1:0]  rem_nxt;
    logic [L-1:0]  quo_nxt;
    logic [L-1:0]  lui_val;

    // Operand selection, decode and one iteration step of each datapath.
    always_comb begin
        opb_sel      = UseImmediate ? imm : rs2;
        op_mul       = (ALUOpcode == P'(ALU_MUL));
        op_div       = (ALUOpcode == P'(ALU_DIV));
        lui_val      = {imm[L/2-1:0], {(L - L/2){1'b0}}};
        last_iter    = (cnt == CW'(L - 1));

        mul_part_nxt = opb[0] ? (part + opa) : part;

        // Restoring step: shift next dividend bit into the remainder and
        // keep the subtraction only when it does not go negative.
        rem_sh       = {part, opa[L-1]};
        trial        = rem_sh - {1'b0, opb};
        div_ok       = ~trial[L];
        rem_nxt      = div_ok ? trial[L-1:0] : rem_sh[L-1:0];
        quo_nxt      = {opa[L-2:0], div_ok};
    end

    // Sequencing FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            opa         <= '0;
            opb         <= '0;
            part        <= '0;
            result      <= '0;
            div_by_zero <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready <= 1'b0;
                        opa      <= rs1;
                        opb      <= opb_sel;
                        part     <= '0;
                        cnt      <= '0;
                        if (LoadUpperImmediate) begin
                            state       <= DONE;
                            result      <= lui_val;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                        end else if (op_mul) begin
                            state <= MUL;
                        end else if (op_div && (opb_sel == '0)) begin
                            state       <= DONE;
                            result      <= '1;
                            div_by_zero <= 1'b1;
                            out_valid   <= 1'b1;
                        end else if (op_div) begin
                            state <= DIV;
                        end else begin
                            // Opcode outside the defined set (only for P > 1).
                            state       <= DONE;
                            result      <= '0;
                            div_by_zero <= 1'b0;
                            out_valid   <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    part <= mul_part_nxt;
                    opa  <= opa << 1;
                    opb  <= opb >> 1;
                    if (last_iter) begin
                        cnt       <= '0;
                        state     <= DONE;
                        result    <= mul_part_nxt;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DIV: begin
                    part <= rem_nxt;
                    opa  <= quo_nxt;
                    if (last_iter) begin
                        cnt         <= '0;
                        state       <= DONE;
                        result      <= quo_nxt;
                        div_by_zero <= 1'b0;
                        out_valid   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state       <= IDLE;
                        out_valid   <= 1'b0;
                        in_ready    <= 1'b1;
                        result      <= '0;
                        div_by_zero <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_exec_unit.sv
// Self-checking bench for muldiv_exec_unit: directed cases, randomized
// operations against an arithmetic reference model, backpressure and reset.
module tb_muldiv_exec_unit;

    localparam int L = 16;
    localparam int P = 1;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [P-1:0] ALUOpcode;
    logic         UseImmediate;
    logic         LoadUpperImmediate;
    logic [L-1:0] rs1;
    logic [L-1:0] rs2;
    logic [L-1:0] imm;
    logic         out_valid;
    logic         out_ready;
    logic [L-1:0] result;
    logic         div_by_zero;

    int vectors;
    int miscompares;

    muldiv_exec_unit #(.L(L), .P(P)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .ALUOpcode          (ALUOpcode),
        .UseImmediate       (UseImmediate),
        .LoadUpperImmediate (LoadUpperImmediate),
        .rs1                (rs1),
        .rs2                (rs2),
        .imm                (imm),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .result             (result),
        .div_by_zero        (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain arithmetic on the operation's meaning.
    function automatic logic [L:0] ref_op(input logic lui, input logic op, input logic ui,
                                          input logic [L-1:0] a, input logic [L-1:0] r2,
                                          input logic [L-1:0] im, output int lat);
        logic [L-1:0]   b;
        logic [2*L-1:0] prod;
        logic [L-1:0]   quo;
        b = ui ? im : r2;
        if (lui) begin
            lat = 1;
            return {1'b0, im[7:0], 8'h00};
        end else if (op) begin
            lat  = L + 1;
            prod = a * b;
            return {1'b0, prod[L-1:0]};
        end else if (b == 0) begin
            lat = 1;
            return {1'b1, {L{1'b1}}};
        end else begin
            lat = L + 1;
            quo = a / b;
            return {1'b0, quo};
        end
    endfunction

    task automatic scramble_inputs();
        ALUOpcode          = P'($urandom);
        UseImmediate       = 1'($urandom);
        LoadUpperImmediate = 1'($urandom);
        rs1                = L'($urandom);
        rs2                = L'($urandom);
        imm                = L'($urandom);
    endtask

    // Issues one operation, checks latency, result and flag, holds the
    // result for 'hold' cycles with junk requests, then hands it off.
    // Entered and left at #1 after a rising edge.
    task automatic run_op(input logic lui, input logic op, input logic ui,
                          input logic [L-1:0] a, input logic [L-1:0] r2,
                          input logic [L-1:0] im, input int hold, input string tag);
        logic [L:0] exp;
        int         exp_lat;
        int         lat;
        int         n;
        exp = ref_op(lui, op, ui, a, r2, im, exp_lat);

        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s ready_wait: in_ready=%b required 1", tag, in_ready);
        end

        in_valid           = 1'b1;
        ALUOpcode          = P'(op);
        UseImmediate       = ui;
        LoadUpperImmediate = lui;
        rs1                = a;
        rs2                = r2;
        imm                = im;
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_inputs();

        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL %s busy_ready: in_ready=%b required 0", tag, in_ready);
            end
            in_valid = 1'($urandom);
            scramble_inputs();
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;

        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL %s out_valid_timeout: out_valid=%b required 1", tag, out_valid);
        end
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s latency: got %0d required %0d", tag, lat, exp_lat);
        end
        vectors++;
        if (result !== exp[L-1:0]) begin
            miscompares++;
            $display("FAIL %s result: got %h required %h", tag, result, exp[L-1:0]);
        end
        vectors++;
        if (div_by_zero !== exp[L]) begin
            miscompares++;
            $display("FAIL %s div_by_zero: got %b required %b", tag, div_by_zero, exp[L]);
        end

        for (int i = 0; i < hold; i++) begin
            out_ready = 1'b0;
            in_valid  = 1'b1;
            scramble_inputs();
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== exp[L-1:0]
                || div_by_zero !== exp[L]) begin
                miscompares++;
                $display("FAIL %s hold%0d: valid=%b ready=%b result=%h dbz=%b required 1 0 %h %b",
                         tag, i, out_valid, in_ready, result, div_by_zero, exp[L-1:0], exp[L]);
            end
        end
        in_valid  = 1'b0;

        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s handoff: out_valid=%b in_ready=%b required 0 1",
                     tag, out_valid, in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n              = 1'b1;
        in_valid           = 1'b0;
        out_ready          = 1'b0;
        ALUOpcode          = '0;
        UseImmediate       = 1'b0;
        LoadUpperImmediate = 1'b0;
        rs1                = '0;
        rs2                = '0;
        imm                = '0;
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_values: ready=%b valid=%b result=%h dbz=%b required 1 0 0000 0",
                     in_ready, out_valid, result, div_by_zero);
        end
        // Requests during reset must not be taken.
        in_valid           = 1'b1;
        LoadUpperImmediate = 1'b1;
        imm                = 16'h00FF;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            miscompares++;
            $display("FAIL reset_hold: ready=%b valid=%b result=%h required 1 0 0000",
                     in_ready, out_valid, result);
        end
        in_valid           = 1'b0;
        LoadUpperImmediate = 1'b0;
        rst_n              = 1'b1;
    endtask

    task automatic test_directed();
        run_op(1'b0, 1'b1, 1'b0, 16'd7,     16'd6,     16'hDEAD, 0, "mul_7x6");
        run_op(1'b0, 1'b1, 1'b1, 16'h0300,  16'h1234,  16'h0100, 0, "muli_trunc");
        run_op(1'b0, 1'b0, 1'b0, 16'd100,   16'd7,     16'h0000, 0, "div_100_7");
        run_op(1'b0, 1'b0, 1'b1, 16'd5,     16'd3,     16'h0000, 0, "divi_by_zero");
        run_op(1'b1, 1'b1, 1'b0, 16'h1234,  16'h5678,  16'h00AB, 0, "lui_ab");
        run_op(1'b0, 1'b1, 1'b0, 16'hFFFF,  16'hFFFF,  16'h0000, 0, "mul_max");
        run_op(1'b0, 1'b0, 1'b0, 16'hFFFF,  16'd1,     16'h0000, 0, "div_by_one");
        run_op(1'b0, 1'b0, 1'b0, 16'd3,     16'hFFFF,  16'h0000, 0, "div_small");
        run_op(1'b1, 1'b0, 1'b0, 16'h0000,  16'h0000,  16'hBEEF, 0, "lui_over_div");
    endtask

    task automatic test_backpressure();
        run_op(1'b0, 1'b0, 1'b0, 16'd1000, 16'd9, 16'h0000, 5, "backpressure_div");
        run_op(1'b1, 1'b0, 1'b0, 16'd0,    16'd0, 16'h0042, 5, "backpressure_lui");
    endtask

    task automatic test_random();
        logic         lui;
        logic         op;
        logic         ui;
        logic [L-1:0] a;
        logic [L-1:0] r2;
        logic [L-1:0] im;
        for (int k = 0; k < 40; k++) begin
            lui = (($urandom % 8) == 0);
            op  = 1'($urandom);
            ui  = 1'($urandom);
            a   = L'($urandom);
            r2  = (($urandom % 4) == 0) ? L'($urandom % 4) : L'($urandom);
            im  = (($urandom % 4) == 0) ? L'($urandom % 4) : L'($urandom);
            run_op(lui, op, ui, a, r2, im, int'($urandom % 3), $sformatf("rand%0d", k));
        end
    endtask

    task automatic test_reset_mid_op();
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        in_valid           = 1'b1;
        ALUOpcode          = 1'b0;
        UseImmediate       = 1'b0;
        LoadUpperImmediate = 1'b0;
        rs1                = 16'd200;
        rs2                = 16'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0 || div_by_zero !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_values: ready=%b valid=%b result=%h dbz=%b required 1 0 0000 0",
                     in_ready, out_valid, result, div_by_zero);
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            vectors++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL midreset_abort%0d: valid=%b ready=%b required 0 1",
                         i, out_valid, in_ready);
            end
            if (i == 2) rst_n = 1'b1;
        end
        run_op(1'b0, 1'b1, 1'b0, 16'd3, 16'd3, 16'h0000, 0, "mul_after_reset");
    endtask

    // Restart straight after deassertion: accept must occur on the first edge.
    task automatic test_first_edge_accept();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        run_op(1'b1, 1'b0, 1'b0, 16'd0, 16'd0, 16'h0017, 0, "first_edge_lui");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        @(posedge clk); #1;
        test_directed();
        test_backpressure();
        test_random();
        test_reset_mid_op();
        test_first_edge_accept();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d vectors applied", vectors);
        $fatal(1);
    end

endmodule

// File: doc/muldiv_exec_unit.md
MULDIV_EXEC_UNIT -- requirements
Module: muldiv_exec_unit

Interface
REQ-001 The block SHALL have parameter L, default 16, meaning the datapath width in bits.
REQ-002 The block SHALL have parameter P, default 1, meaning the ALUOpcode width in bits.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 The port clk SHALL be an input of width 1: the single clock, rising edge.
REQ-005 The port rst_n SHALL be an input of width 1: asynchronous active-low reset.
REQ-006 The port in_valid SHALL be an input of width 1: the request is valid.
REQ-007 The port in_ready SHALL be an output of width 1: the block can accept a request.
REQ-008 The port ALUOpcode SHALL be an input of width P: 1 = multiply, 0 = divide.
REQ-009 The port UseImmediate SHALL be an input of width 1: the second operand is imm, not rs2.
REQ-010 The port LoadUpperImmediate SHALL be an input of width 1: LUI operation.
REQ-011 The port rs1 SHALL be an input of width L: the first operand.
REQ-012 The port rs2 SHALL be an input of width L: the second register operand.
REQ-013 The port imm SHALL be an input of width L: the immediate, already extended by the decode stage.
REQ-014 The port out_valid SHALL be an output of width 1: result is valid.
REQ-015 The port out_ready SHALL be an input of width 1: the consumer accepts the result.
REQ-016 The port result SHALL be an output of width L: the operation result.
REQ-017 The port div_by_zero SHALL be an output of width 1: flag qualifying result.

Function
REQ-018 The block SHALL implement states IDLE, MUL, DIV and DONE.
REQ-019 in_ready SHALL be 1 only in IDLE; a request is accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-020 On accept, the block SHALL latch rs1, and imm if UseImmediate = 1 or rs2 otherwise, as operand B.
REQ-021 On accept, the block SHALL decode the operation with priority LoadUpperImmediate > ALUOpcode.
REQ-022 For LUI, the block SHALL go to DONE with result = {imm[7:0], 8'h00} (generally imm[L/2-1:0] shifted left by L/2) and div_by_zero = 0.
REQ-023 For MUL, the block SHALL perform an unsigned shift-add multiply, one bit per cycle, over L cycles; result SHALL be the low L bits of the product.
REQ-024 For DIV with B != 0, the block SHALL perform an unsigned restoring divide, one quotient bit per cycle, over L cycles; result SHALL be the quotient.
REQ-025 For DIV with B = 0, the block SHALL go directly to DONE with result = all-ones and div_by_zero = 1, and SHALL NOT enter the DIV state.
REQ-026 The iteration counter SHALL count 0..L-1; after the L-th iteration the state SHALL be DONE.
REQ-027 MUL/DIV latency SHALL be L+1 cycles from the accept edge to the first cycle with out_valid = 1 (17 cycles for L = 16).
REQ-028 LUI and divide-by-zero latency SHALL be 1 cycle.
REQ-029 In DONE, out_valid SHALL be 1, and result and div_by_zero SHALL be held stable until out_ready = 1, at which point the state SHALL return to IDLE on that edge.
REQ-030 There SHALL be no same-cycle result-to-accept bypass: the next request is accepted no earlier than one cycle after the result handshake.
REQ-031 in_valid and input changes while not in IDLE SHALL be ignored.
REQ-032 In the MUL and DIV states, result and div_by_zero SHALL not be observable; out_valid SHALL be 0.

Reset
REQ-033 When rst_n = 0, the block SHALL force state = IDLE, counter = 0, and operand and partial registers = 0.
REQ-034 When rst_n = 0, the block SHALL drive result = 0, div_by_zero = 0, out_valid = 0 and in_ready = 1 (held while rst_n = 0).
REQ-035 Reset asserted mid-operation SHALL abort the operation with no result produced.
REQ-036 The first accept SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-037 Shared package muldiv_pkg SHALL hold the state enum, the ALU_MUL = 1 and ALU_DIV = 0 constants, and CNT_W = $clog2(L).
REQ-038 The block SHALL be single-module with no sub-module, since the iteration datapath is small.
REQ-039 The block SHALL register all outputs.

Verification
REQ-040 MUL rs1 = 7, rs2 = 6 -> out_valid 17 cycles after accept, result = 42, div_by_zero = 0.
REQ-041 MULi rs1 = 0x0300, imm = 0x0100 -> result = 0x0000 (truncated low 16 bits); DIV rs1 = 100, rs2 = 7 -> result = 14.
REQ-042 DIVi rs1 = 5, imm = 0 -> one cycle later result = 0xFFFF, div_by_zero = 1.
REQ-043 LUI imm = 0x00AB (LoadUpperImmediate = 1, ALUOpcode = 1) -> one cycle later result = 0xAB00, div_by_zero = 0.
REQ-044 Hold out_ready = 0 for 5 cycles in DONE while driving new in_valid requests -> result held, in_ready = 0, no accept; release out_ready -> IDLE next cycle.
REQ-045 Assert rst_n = 0 at iteration 8 of a DIV -> out_valid never rises, in_ready = 1, result = 0; a following MUL 3 x 3 -> result = 9.
